// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle for wb_timer.
// The Peripheral modport is the responder view and the Controller modport is the requester view.
interface Wishbone;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport Peripheral (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );

    modport Controller (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );
endinterface

// File: rtl/wb_timer.sv
// RISC-V style machine timer (mtime/mtimecmp) behind a Wishbone classic responder.
// Define WB_TIMER_ERR_EN to answer unmapped addresses with err instead of a zero-data ack.
module wb_timer #(
    parameter logic [15:0] PRESCALE_RESET = 16'h0000,
    parameter logic        IRQ_EN_RESET   = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    Wishbone.Peripheral wb,
    output logic        o_irq
);

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;
    localparam logic [2:0] REG_PRESCALE    = 3'd5;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow;
    logic [15:0] count;
    logic [15:0] prescale;
    logic        enable;
    logic        irq_en;
    logic        irq;

    logic        ack;
    logic        err;
    logic [31:0] dat_r;
    logic [31:0] rdata;

    logic [2:0]  idx;
    logic        mapped;
    logic        req;
    logic        rd;
    logic        wr;
    logic        wr_mtime;
    logic        tick;
    logic        unused_adr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (data & mask) | (old & ~mask);
    endfunction

    // A new request is only taken while no response is on the bus, so a held strobe alternates.
    assign idx        = wb.adr[4:2];
    assign mapped     = (idx <= REG_PRESCALE);
    assign req        = wb.cyc && wb.stb && !(ack || err);
    assign rd         = req && !wb.we && mapped;
    assign wr         = req && wb.we && mapped && (wb.sel != 4'b0000);
    assign wr_mtime   = wr && ((idx == REG_MTIME_LO) || (idx == REG_MTIME_HI));
    assign tick       = enable && (count == prescale);
    assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};

    always_comb begin
        rdata = '0;
        case (idx)
            REG_MTIME_LO:    rdata = mtime[31:0];
            REG_MTIME_HI:    rdata = shadow;
            REG_MTIMECMP_LO: rdata = mtimecmp[31:0];
            REG_MTIMECMP_HI: rdata = mtimecmp[63:32];
            REG_CTRL:        rdata = {30'b0, irq_en, enable};
            REG_PRESCALE:    rdata = {16'b0, prescale};
            default:         rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack   <= 1'b0;
            dat_r <= '0;
        end else begin
`ifdef WB_TIMER_ERR_EN
            ack   <= req && mapped;
`else
            ack   <= req;
`endif
            dat_r <= rd ? rdata : '0;
        end
    end

`ifdef WB_TIMER_ERR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err <= 1'b0;
        end else begin
            err <= req && !mapped;
        end
    end
`else
    assign err = 1'b0;
`endif

    // A software write to mtime replaces the tick of that cycle rather than adding to it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime <= '0;
            count <= '0;
        end else begin
            if (wr && (idx == REG_MTIME_LO)) begin
                mtime <= {mtime[63:32], merge_bytes(mtime[31:0], wb.dat_w, wb.sel)};
            end else if (wr && (idx == REG_MTIME_HI)) begin
                mtime <= {merge_bytes(mtime[63:32], wb.dat_w, wb.sel), mtime[31:0]};
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_mtime || (wr && (idx == REG_PRESCALE)) || tick) begin
                count <= '0;
            end else if (enable) begin
                count <= count + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtimecmp <= '1;
            enable   <= 1'b0;
            irq_en   <= IRQ_EN_RESET;
            prescale <= PRESCALE_RESET;
            shadow   <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr) begin
                case (idx)
                    REG_MTIMECMP_LO: mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wb.dat_w, wb.sel);
                    REG_MTIMECMP_HI: mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wb.dat_w, wb.sel);
                    REG_CTRL: begin
                        if (wb.sel[0]) begin
                            enable <= wb.dat_w[0];
                            irq_en <= wb.dat_w[1];
                        end
                    end
                    REG_PRESCALE: begin
                        prescale <= {wb.sel[1] ? wb.dat_w[15:8] : prescale[15:8],
                                     wb.sel[0] ? wb.dat_w[7:0]  : prescale[7:0]};
                    end
                    default: ;
                endcase
            end
            // Reading the low word freezes the high word so a LO/HI pair is coherent.
            if (rd && (idx == REG_MTIME_LO)) begin
                shadow <= mtime[63:32];
            end
            irq <= irq_en && (mtime >= mtimecmp);
        end
    end

    assign wb.ack   = ack;
    assign wb.err   = err;
    assign wb.dat_r = dat_r;
    assign o_irq    = irq;

endmodule

// File: tb/tb_wb_timer.sv
// Directed plus randomized bench for wb_timer; the random phase is checked against a register-level model.
// Expectations for unmapped addresses follow WB_TIMER_ERR_EN.
module tb_wb_timer;

    localparam logic [31:0] A_MTIME_LO    = 32'h00;
    localparam logic [31:0] A_MTIME_HI    = 32'h04;
    localparam logic [31:0] A_MTIMECMP_LO = 32'h08;
    localparam logic [31:0] A_MTIMECMP_HI = 32'h0C;
    localparam logic [31:0] A_CTRL        = 32'h10;
    localparam logic [31:0] A_PRESCALE    = 32'h14;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic irq;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [15:0] m_pre;
    logic        m_en;
    logic        m_irq_en;

    Wishbone bus ();

    wb_timer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (bus),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [63:0] got,
                               input logic [63:0] lo, input logic [63:0] hi);
        n_cmp++;
        assert (got >= lo && got <= hi) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h..0x%0h", tag, got, lo, hi);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                  input logic [3:0] sel, output logic [31:0] rdata,
                                  output logic ack, output logic err);
        @(posedge clk);
        @(negedge clk);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = adr;
        bus.dat_w = dat;
        bus.sel   = sel;
        @(posedge clk);
        #1;
        rdata   = bus.dat_r;
        ack     = bus.ack;
        err     = bus.err;
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic write_reg(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
        logic [31:0] r;
        logic a, e;
        apply_stimulus(1'b1, adr, dat, sel, r, a, e);
        check_output({tag, " ack"}, a, 64'd1);
    endtask

    task automatic read_reg(input string tag, input logic [31:0] adr, output logic [31:0] data);
        logic a, e;
        apply_stimulus(1'b0, adr, 32'h0, 4'hF, data, a, e);
        check_output({tag, " ack"}, a, 64'd1);
    endtask

    task automatic check_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        read_reg(tag, adr, d);
        check_output(tag, d, exp);
    endtask

    function automatic logic [31:0] model_write32(input logic [31:0] old, input logic [31:0] data,
                                                  input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    initial begin
        logic [31:0] r, lo, hi, dat, adr, exp_d;
        logic        a, e, exp_a, exp_e, we;
        logic [2:0]  idx;
        logic [3:0]  sel;
        int          first_k;

        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.adr = '0;   bus.dat_w = '0; bus.sel = '0;

        #2 rst_n = 1'b0;
        #1;
        check_output("reset ack", bus.ack, 64'd0);
        check_output("reset err", bus.err, 64'd0);
        check_output("reset dat_r", bus.dat_r, 64'd0);
        check_output("reset irq", irq, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        check_read("rst mtime_lo", A_MTIME_LO, 32'h0);
        check_read("rst mtime_hi", A_MTIME_HI, 32'h0);
        check_read("rst cmp_lo", A_MTIMECMP_LO, 32'hFFFF_FFFF);
        check_read("rst cmp_hi", A_MTIMECMP_HI, 32'hFFFF_FFFF);
        check_read("rst ctrl", A_CTRL, 32'h0);
        check_read("rst prescale", A_PRESCALE, 32'h0);

        // Held request: answered on alternate cycles; strobe without cyc is ignored.
        @(posedge clk);
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = A_CTRL; bus.sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_output($sformatf("held ack %0d", k), bus.ack, 64'((k % 2) == 0));
        end
        bus.cyc = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check_output($sformatf("no-cyc ack %0d", k), bus.ack, 64'd0);
        end
        bus.stb = 1'b0;

        write_reg("cmp_lo sel0010", A_MTIMECMP_LO, 32'hAABB_CCDD, 4'b0010);
        check_read("cmp_lo byte merge", A_MTIMECMP_LO, 32'hFFFF_CCFF);
        write_reg("cmp_lo sel0", A_MTIMECMP_LO, 32'h0, 4'b0000);
        check_read("cmp_lo after sel0", A_MTIMECMP_LO, 32'hFFFF_CCFF);
        check_read("cmp_lo alias 0x28", 32'h28, 32'hFFFF_CCFF);

        apply_stimulus(1'b0, 32'h18, 32'h0, 4'hF, r, a, e);
`ifdef WB_TIMER_ERR_EN
        check_output("unmapped rd err", e, 64'd1);
        check_output("unmapped rd ack", a, 64'd0);
`else
        check_output("unmapped rd ack", a, 64'd1);
        check_output("unmapped rd err", e, 64'd0);
`endif
        check_output("unmapped rd dat_r", r, 64'd0);
        apply_stimulus(1'b1, 32'h1C, 32'h1234_5678, 4'hF, r, a, e);
`ifdef WB_TIMER_ERR_EN
        check_output("unmapped wr err", e, 64'd1);
`else
        check_output("unmapped wr ack", a, 64'd1);
`endif
        check_read("ctrl after unmapped", A_CTRL, 32'h0);

        // Prescale 3 => one tick per four enabled cycles.
        write_reg("prescale=3", A_PRESCALE, 32'd3, 4'hF);
        write_reg("ctrl=1", A_CTRL, 32'd1, 4'hF);
        repeat (40) @(posedge clk);
        read_reg("prescaled mtime", A_MTIME_LO, lo);
        check_range("prescaled mtime", 64'(lo), 64'd9, 64'd11);

        write_reg("ctrl=0", A_CTRL, 32'd0, 4'hF);
        write_reg("mtime_hi=0", A_MTIME_HI, 32'h0, 4'hF);
        write_reg("mtime_lo", A_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
        write_reg("prescale=0", A_PRESCALE, 32'd0, 4'hF);
        write_reg("ctrl=1", A_CTRL, 32'd1, 4'hF);
        for (int k = 0; k < 3; k++) begin
            read_reg("carry lo", A_MTIME_LO, lo);
            read_reg("carry hi", A_MTIME_HI, hi);
            check_output($sformatf("carry pair %0d hi", k), 64'(hi),
                         (lo >= 32'hFFFF_FF00) ? 64'd0 : 64'd1);
            check_range($sformatf("carry pair %0d value", k), {hi, lo},
                        64'hFFFF_FFFE, 64'h1_0000_0020);
        end

        write_reg("wrap hi", A_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
        write_reg("wrap lo", A_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
        read_reg("wrap lo", A_MTIME_LO, lo);
        read_reg("wrap hi", A_MTIME_HI, hi);
        check_range("wrap lo value", 64'(lo), 64'd0, 64'd3);
        check_output("wrap hi value", hi, 64'd0);

        // With mtime counting from zero each cycle, irq follows mtime==100 by one cycle.
        write_reg("ctrl=0", A_CTRL, 32'd0, 4'hF);
        write_reg("mtime_lo=0", A_MTIME_LO, 32'd0, 4'hF);
        write_reg("mtime_hi=0", A_MTIME_HI, 32'd0, 4'hF);
        write_reg("cmp_hi=0", A_MTIMECMP_HI, 32'd0, 4'hF);
        write_reg("cmp_lo=100", A_MTIMECMP_LO, 32'd100, 4'hF);
        write_reg("prescale=0", A_PRESCALE, 32'd0, 4'hF);
        write_reg("ctrl=3", A_CTRL, 32'd3, 4'hF);
        first_k = 0;
        for (int k = 1; k <= 200 && first_k == 0; k++) begin
            @(posedge clk); #1;
            if (irq) first_k = k;
        end
        check_output("irq rise cycle", 64'(first_k), 64'd101);
        write_reg("cmp_lo=1000", A_MTIMECMP_LO, 32'd1000, 4'hF);
        @(posedge clk); #1;
        check_output("irq after cmp raise", irq, 64'd0);
        write_reg("cmp_lo=0", A_MTIMECMP_LO, 32'd0, 4'hF);
        @(posedge clk); #1;
        check_output("irq after cmp drop", irq, 64'd1);
        write_reg("ctrl=1", A_CTRL, 32'd1, 4'hF);
        @(posedge clk); #1;
        check_output("irq after irq_en clear", irq, 64'd0);

        // Random register traffic with the timer frozen and irq_en set.
        write_reg("ctrl=2", A_CTRL, 32'd2, 4'hF);
        m_en = 1'b0; m_irq_en = 1'b1;
        m_mtime = {32'h0000_0010, 32'h1234_5678};
        m_cmp   = {32'h0000_0010, $urandom};
        m_pre   = 16'h00AB;
        write_reg("seed mtime_lo", A_MTIME_LO, m_mtime[31:0], 4'hF);
        write_reg("seed mtime_hi", A_MTIME_HI, m_mtime[63:32], 4'hF);
        write_reg("seed cmp_lo", A_MTIMECMP_LO, m_cmp[31:0], 4'hF);
        write_reg("seed cmp_hi", A_MTIMECMP_HI, m_cmp[63:32], 4'hF);
        write_reg("seed prescale", A_PRESCALE, {16'h0, m_pre}, 4'hF);
        check_read("seed mtime_lo", A_MTIME_LO, m_mtime[31:0]);
        m_shadow = m_mtime[63:32];
        for (int i = 0; i < 60; i++) begin
            idx = 3'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            if (idx == 3'd4) we = 1'b0;
            sel = 4'($urandom);
            dat = $urandom;
            adr = {27'($urandom), idx, 2'($urandom)};
            exp_d = 32'h0; exp_a = 1'b1; exp_e = 1'b0;
            if (idx >= 3'd6) begin
`ifdef WB_TIMER_ERR_EN
                exp_a = 1'b0; exp_e = 1'b1;
`endif
            end else if (we) begin
                case (idx)
                    3'd0: m_mtime[31:0]  = model_write32(m_mtime[31:0], dat, sel);
                    3'd1: m_mtime[63:32] = model_write32(m_mtime[63:32], dat, sel);
                    3'd2: m_cmp[31:0]    = model_write32(m_cmp[31:0], dat, sel);
                    3'd3: m_cmp[63:32]   = model_write32(m_cmp[63:32], dat, sel);
                    3'd5: m_pre          = 16'(model_write32({16'h0, m_pre}, dat, sel));
                    default: ;
                endcase
            end else begin
                case (idx)
                    3'd0: begin exp_d = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
                    3'd1: exp_d = m_shadow;
                    3'd2: exp_d = m_cmp[31:0];
                    3'd3: exp_d = m_cmp[63:32];
                    3'd4: exp_d = {30'b0, m_irq_en, m_en};
                    3'd5: exp_d = {16'b0, m_pre};
                    default: ;
                endcase
            end
            apply_stimulus(we, adr, dat, sel, r, a, e);
            check_output($sformatf("rand %0d ack", i), a, 64'(exp_a));
            check_output($sformatf("rand %0d err", i), e, 64'(exp_e));
            check_output($sformatf("rand %0d dat_r", i), r, 64'(exp_d));
            @(posedge clk); #1;
            check_output($sformatf("rand %0d irq", i), irq, 64'(m_irq_en && (m_mtime >= m_cmp)));
        end

        // Reset while a response is showing, then a request waiting across reset release.
        write_reg("ctrl=2", A_CTRL, 32'd2, 4'hF);
        write_reg("cmp_hi=0", A_MTIMECMP_HI, 32'd0, 4'hF);
        write_reg("cmp_lo=0", A_MTIMECMP_LO, 32'd0, 4'hF);
        @(posedge clk); #1;
        check_output("irq before reset", irq, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = A_CTRL; bus.sel = 4'hF;
        @(posedge clk); #1;
        check_output("pre-reset ack", bus.ack, 64'd1);
        check_output("pre-reset dat_r", bus.dat_r, 64'd2);
        rst_n = 1'b0;
        #1;
        check_output("async reset ack", bus.ack, 64'd0);
        check_output("async reset dat_r", bus.dat_r, 64'd0);
        check_output("async reset irq", irq, 64'd0);
        bus.adr = A_MTIMECMP_LO;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("first edge ack", bus.ack, 64'd1);
        check_output("first edge dat_r", bus.dat_r, 64'hFFFF_FFFF);
        bus.cyc = 1'b0; bus.stb = 1'b0;

        // Reset arriving before the accepting edge of a read discards it.
        write_reg("ctrl=3", A_CTRL, 32'd3, 4'hF);
        write_reg("cmp_hi=0", A_MTIMECMP_HI, 32'd0, 4'hF);
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = A_CTRL; bus.sel = 4'hF;
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_output("flight ack in reset", bus.ack, 64'd0);
        @(posedge clk); #1;
        check_output("flight ack edge", bus.ack, 64'd0);
        bus.cyc = 1'b0; bus.stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_output($sformatf("flight ack after %0d", k), bus.ack, 64'd0);
            check_output($sformatf("flight err after %0d", k), bus.err, 64'd0);
        end
        check_read("post-reset ctrl", A_CTRL, 32'h0);
        check_read("post-reset cmp_hi", A_MTIMECMP_HI, 32'hFFFF_FFFF);
        check_read("post-reset mtime_lo", A_MTIME_LO, 32'h0);
        check_output("post-reset irq", irq, 64'd0);

        $display("[TB] done");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter PRESCALE_RESET, default 16'h0000, reset value of the PRESCALE register.
REQ-002 SHALL have parameter IRQ_EN_RESET, default 1'b0, reset value of CTRL.irq_en.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wb  Wishbone.Peripheral  --  Wishbone classic responder: cyc, stb, we in 1b; adr in 32b; dat_w in 32b; sel in 4b; dat_r out 32b; ack out 1b; err out 1b.
REQ-006 SHALL have port o_irq  output  1  machine timer interrupt, level.

Function
REQ-007 SHALL decode adr[4:2] only (word-aligned): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 enable, bit1 irq_en, others read 0), 5 PRESCALE (bits 15:0; others read 0); 6-7 unmapped.
REQ-008 SHALL accept a request in a cycle where cyc && stb && !ack, and assert exactly one of ack/err for exactly one cycle in the next cycle.
REQ-009 SHALL ignore stb while cyc is low; a request held continuously SHALL be answered every second cycle (request, response, request, ...).
REQ-010 SHALL present read data on dat_r in the cycle ack is high; dat_r SHALL be 0 when ack is low.
REQ-011 SHALL apply writes byte-wise per sel[3:0]; sel=0 writes SHALL be acknowledged with no state change.
REQ-012 SHALL hold a 16-bit prescale counter: when enable=1, counter increments each cycle; when counter == PRESCALE, counter SHALL clear to 0 and mtime (64-bit) SHALL increment by 1 the same cycle; PRESCALE=0 gives one tick per cycle.
REQ-013 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no other side effect.
REQ-014 SHALL, when enable=0, freeze both mtime and the prescale counter.
REQ-015 SHALL, on a write to MTIME_LO/HI coinciding with a tick, store the written bytes and the unwritten bytes without the increment (write wins; tick lost).
REQ-016 SHALL clear the prescale counter on any write to PRESCALE or MTIME_LO/HI.
REQ-017 SHALL, on a read of MTIME_LO, return mtime[31:0] and latch mtime[63:32] into a shadow register the same cycle; reads of MTIME_HI SHALL return the shadow, never live mtime.
REQ-018 SHALL drive o_irq from a register: o_irq(next) = irq_en && (mtime >= mtimecmp), unsigned 64-bit compare, evaluated every cycle on current values.
REQ-019 SHALL deassert o_irq one cycle after a write that makes mtimecmp > mtime or clears irq_en.

Reset
REQ-020 SHALL, while i_rst_n=0, immediately force ack=0, err=0, dat_r=0, o_irq=0.
REQ-021 SHALL reset mtime=0, shadow=0, prescale counter=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, enable=0, irq_en=IRQ_EN_RESET, PRESCALE=PRESCALE_RESET.
REQ-022 SHALL discard any request in flight when reset asserts; no ack/err SHALL be issued for it after release.
REQ-023 SHALL accept a new request on the first rising edge after i_rst_n deasserts.

Configuration
REQ-024 SHALL, with macro WB_TIMER_ERR_EN defined, respond to unmapped addresses (adr[4:2] = 6,7) with err=1, ack=0, no state change.
REQ-025 SHALL, without WB_TIMER_ERR_EN, respond to unmapped addresses with ack=1, dat_r=0, writes ignored; err SHALL be tied 0.

Verification
REQ-026 Bench SHALL cover: write CTRL=1, PRESCALE=3, wait 40 cycles -> MTIME_LO reads 10 (+/-1 for access latency), ack one cycle after each stb.
REQ-027 Bench SHALL cover: write MTIME_HI=0, MTIME_LO=32'hFFFF_FFFE, PRESCALE=0, enable, read LO then HI across the carry -> HI from shadow consistent with LO (LO=FFFF_FFFF/HI=0 or LO=0/HI=1, never LO=0/HI=0).
REQ-028 Bench SHALL cover: mtimecmp=100, irq_en=1, enable, PRESCALE=0 -> o_irq rises one cycle after mtime reaches 100; write MTIMECMP_LO=1000 -> o_irq low next cycle.
REQ-029 Bench SHALL cover: write sel=4'b0010 data 32'hAABB_CCDD to MTIMECMP_LO from reset -> reads 32'hFFFF_CCFF.
REQ-030 Bench SHALL cover: read adr=0x18 -> err=1 with WB_TIMER_ERR_EN, ack=1 and dat_r=0 without.
REQ-031 Bench SHALL cover: assert i_rst_n=0 in the cycle after stb of a read -> ack never asserts; post-release CTRL reads 0, MTIMECMP_HI reads 32'hFFFF_FFFF.
